mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and address-map constants for the two-requester memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DEF_RAMSIZE  = 1024;
    localparam int unsigned IO_SEG_WORDS = 512;
    localparam int unsigned SEG_BOOT_END = 32;
    localparam int unsigned SEG_RAM_END  = SEG_BOOT_END + DEF_RAMSIZE;
    localparam int unsigned SEG_IO_END   = SEG_RAM_END + IO_SEG_WORDS;
    localparam int unsigned STATUS_ADDR  = SEG_IO_END;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        SEL_CPU = 1'b0,
        SEL_IO  = 1'b1
    } sel_e;

    typedef enum logic {
        PICK_FIXED = 1'b0,
        PICK_RR    = 1'b1
    } pick_mode_e;

    // Status word location for a non-default data-RAM size.
    function automatic int unsigned status_addr(input int unsigned ramsize);
        return SEG_BOOT_END + ramsize + IO_SEG_WORDS;
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational 2-way picker: fixed CPU priority or round-robin against the last grant.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic       cpu_req_i,
    input  logic       io_req_i,
    input  sel_e       last_grant_i,
    input  pick_mode_e mode_i,
    output sel_e       winner_c
);

    always_comb begin
        winner_c = SEL_CPU;
        if (cpu_req_i && io_req_i) begin
            // On a tie, round-robin hands the grant to whoever was not served last.
            if ((mode_i == PICK_RR) && (last_grant_i == SEL_CPU)) begin
                winner_c = SEL_IO;
            end
        end else if (io_req_i) begin
            winner_c = SEL_IO;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// CPU / IO-DMA arbiter for the memory data-segment port (IDLE -> ACCESS -> RESP).
// Define MEM_ARBITER_RR_EN for round-robin tie breaking; otherwise the CPU always wins ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned RAMSIZE = 1024
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,

    input  logic             io_req,
    input  logic             io_we,
    input  logic [WIDTH-1:0] io_addr,
    input  logic [WIDTH-1:0] io_wdata,
    output logic             io_gnt,
    output logic             io_rvalid,
    output logic [WIDTH-1:0] io_rdata,

    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,

    output logic             err,
    output logic             busy
);

    localparam logic [WIDTH-1:0] STATUS_W = WIDTH'(status_addr(RAMSIZE));

    state_e           state_q, state_d;
    sel_e             sel_q, sel_d;
    logic             we_q, we_d;
    logic             bad_q, bad_d;

    logic             cpu_gnt_q, cpu_gnt_d, io_gnt_q, io_gnt_d;
    logic             cpu_rvalid_q, cpu_rvalid_d, io_rvalid_q, io_rvalid_d;
    logic [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d, io_rdata_q, io_rdata_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic             err_q, err_d, busy_q, busy_d;

    sel_e             winner_c;
    sel_e             last_c;
    pick_mode_e       mode_c;
    logic             cur_we_c, bad_c;
    logic [WIDTH-1:0] cur_addr_c, cur_wdata_c;

`ifdef MEM_ARBITER_RR_EN
    sel_e last_q, last_d;

    always_comb begin
        last_d = last_q;
        if ((state_q == IDLE) && (cpu_req || io_req)) begin
            last_d = winner_c;
        end
    end

    // IO counts as served last out of reset so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= SEL_IO;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_c = last_q;
    assign mode_c = PICK_RR;
`else
    assign last_c = SEL_IO;
    assign mode_c = PICK_FIXED;
`endif

    mem_arbiter_pick u_pick (
        .cpu_req_i   (cpu_req),
        .io_req_i    (io_req),
        .last_grant_i(last_c),
        .mode_i      (mode_c),
        .winner_c    (winner_c)
    );

    // Winner's request fields and legality; status word is read-only, above it is unmapped.
    always_comb begin
        cur_we_c    = (winner_c == SEL_IO) ? io_we    : cpu_we;
        cur_addr_c  = (winner_c == SEL_IO) ? io_addr  : cpu_addr;
        cur_wdata_c = (winner_c == SEL_IO) ? io_wdata : cpu_wdata;
        bad_c       = (cur_addr_c > STATUS_W) || (cur_we_c && (cur_addr_c == STATUS_W));
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        we_d         = we_q;
        bad_d        = bad_q;
        cpu_gnt_d    = 1'b0;
        io_gnt_d     = 1'b0;
        cpu_rvalid_d = 1'b0;
        io_rvalid_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        io_rdata_d   = io_rdata_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req || io_req) begin
                    state_d     = ACCESS;
                    sel_d       = winner_c;
                    we_d        = cur_we_c;
                    bad_d       = bad_c;
                    cpu_gnt_d   = (winner_c == SEL_CPU);
                    io_gnt_d    = (winner_c == SEL_IO);
                    mem_we_d    = cur_we_c && !bad_c;
                    mem_addr_d  = cur_addr_c;
                    mem_wdata_d = cur_wdata_c;
                    err_d       = bad_c;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                    if (sel_q == SEL_CPU) begin
                        cpu_rvalid_d = 1'b1;
                        cpu_rdata_d  = bad_q ? '0 : mem_rdata;
                    end else begin
                        io_rvalid_d = 1'b1;
                        io_rdata_d  = bad_q ? '0 : mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= SEL_CPU;
            we_q         <= 1'b0;
            bad_q        <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            io_gnt_q     <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            io_rvalid_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            io_rdata_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            bad_q        <= bad_d;
            cpu_gnt_q    <= cpu_gnt_d;
            io_gnt_q     <= io_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            io_rvalid_q  <= io_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            io_rdata_q   <= io_rdata_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign io_gnt     = io_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign io_rvalid  = io_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign io_rdata   = io_rdata_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule
